// File: rtl/bram_read_streamer.sv
// -----------------------------------------------------------------------------
// bram_read_streamer
//
// Reads num_cnt_i consecutive BRAM words starting at address 0 and presents
// them on a valid/ready stream. Reads are only issued while the output FIFO
// has room for every word already in flight, so the BRAM's fixed read latency
// can never overflow the buffer and back-pressure never drops data.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start_i, num_cnt_i     start pulse (IDLE only) and word count 0..2^AWIDTH
//   idle_o, running_o      state flags (IDLE / RUN)
//   done_o                 one-cycle pulse when the sweep has been consumed
//   addr_o, ce_o, we_o     BRAM read port (we_o tied low)
//   q_i                    BRAM read data, valid RD_LAT cycles after ce_o
//   m_valid_o, m_ready_i   output stream handshake
//   m_data_o               output word (FIFO head, 0 when empty)
// -----------------------------------------------------------------------------
module bram_read_streamer #(
   parameter int AWIDTH     = 8,
   parameter int DWIDTH     = 32,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [AWIDTH:0]   num_cnt_i,
   output logic              idle_o,
   output logic              running_o,
   output logic              done_o,
   output logic [AWIDTH-1:0] addr_o,
   output logic              ce_o,
   output logic              we_o,
   input  logic [DWIDTH-1:0] q_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DWIDTH-1:0] m_data_o
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;
   localparam logic [CNTW:0] DEPTH_W = (CNTW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_reg;
   logic [AWIDTH:0]     num_reg;
   logic [AWIDTH:0]     issued_reg;
   logic [AWIDTH:0]     accepted_reg;
   logic [RD_LAT-1:0]   lat_sr_reg;
   logic [DWIDTH-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_reg;
   logic [PW-1:0]       rd_ptr_reg;
   logic [CNTW-1:0]     count_reg;

   logic [CNTW-1:0]     inflight;
   logic [CNTW:0]       occupancy;
   logic                credit_ok;
   logic                push;
   logic                pop;

   // Words already requested from the BRAM but not yet written to the FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNTW'(lat_sr_reg[i]);
      end
   end

   // A read may only be issued if the FIFO can absorb it together with every
   // read still travelling through the BRAM pipeline.
   assign occupancy = {1'b0, count_reg} + {1'b0, inflight};
   assign credit_ok = (occupancy < DEPTH_W);

   assign ce_o      = (state_reg == S_RUN) && (issued_reg < num_reg) && credit_ok;
   assign addr_o    = issued_reg[AWIDTH-1:0];
   assign we_o      = 1'b0;

   assign push      = lat_sr_reg[RD_LAT-1];
   assign m_valid_o = (count_reg != '0);
   assign pop       = m_valid_o && m_ready_i;
   assign m_data_o  = m_valid_o ? fifo_mem[rd_ptr_reg] : '0;

   // Read-latency tracker: one bit per pipeline stage, the tail marks the
   // cycle in which q_i carries a requested word.
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_lat
         if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) lat_sr_reg[gi] <= 1'b0;
               else          lat_sr_reg[gi] <= ce_o;
            end
         end else begin : g_stage
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) lat_sr_reg[gi] <= 1'b0;
               else          lat_sr_reg[gi] <= lat_sr_reg[gi-1];
            end
         end
      end
   endgenerate

   // FIFO storage needs no reset: m_data_o is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= q_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Control FSM with registered status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= S_IDLE;
         num_reg      <= '0;
         issued_reg   <= '0;
         accepted_reg <= '0;
         idle_o       <= 1'b1;
         running_o    <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start_i) begin
                  num_reg      <= num_cnt_i;
                  issued_reg   <= '0;
                  accepted_reg <= '0;
                  idle_o       <= 1'b0;
                  if (num_cnt_i != '0) begin
                     state_reg <= S_RUN;
                     running_o <= 1'b1;
                  end else begin
                     state_reg <= S_DONE;
                     done_o    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (ce_o) issued_reg   <= issued_reg + 1'b1;
               if (pop)  accepted_reg <= accepted_reg + 1'b1;
               // Registered compare: DONE follows the cycle after the last
               // word was accepted.
               if (accepted_reg == num_reg) begin
                  state_reg <= S_DONE;
                  running_o <= 1'b0;
                  done_o    <= 1'b1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               done_o    <= 1'b0;
               idle_o    <= 1'b1;
            end
            default: begin
               state_reg <= S_IDLE;
               running_o <= 1'b0;
               done_o    <= 1'b0;
               idle_o    <= 1'b1;
            end
         endcase
      end
   end

   // The credit rule makes a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && !pop && (count_reg == CNTW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_bram_read_streamer.sv
// -----------------------------------------------------------------------------
// tb_bram_read_streamer
//
// Drives two streamers in lock-step (RD_LAT = 1 and RD_LAT = 2) from a shared
// BRAM image. The reference model is the plain expectation "the k-th word
// requested is at address k, the k-th word delivered is mem[k]", plus the
// closed-form cycle timing for an always-ready consumer.
// -----------------------------------------------------------------------------
module tb_bram_read_streamer;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW:0]   num_cnt;
   logic          ready;

   logic          idle_w    [2];
   logic          running_w [2];
   logic          done_w    [2];
   logic [AW-1:0] addr_w    [2];
   logic          ce_w      [2];
   logic          we_w      [2];
   logic [DW-1:0] q_w       [2];
   logic          valid_w   [2];
   logic [DW-1:0] data_w    [2];

   logic [DW-1:0] mem [256];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int base  = 0;

   // Per-instance observation records.
   int            n_ce      [2];
   int            n_acc     [2];
   int            n_done    [2];
   int            first_ce  [2];
   int            last_ce   [2];
   int            first_v   [2];
   int            done_cyc  [2];
   logic          hold_v    [2];
   logic [DW-1:0] hold_d    [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         logic [DW-1:0] pipe_d [2];
         logic          pipe_v [2];

         bram_read_streamer #(
            .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(gi + 1), .FIFO_DEPTH(FD)
         ) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start_i   (start),
            .num_cnt_i (num_cnt),
            .idle_o    (idle_w[gi]),
            .running_o (running_w[gi]),
            .done_o    (done_w[gi]),
            .addr_o    (addr_w[gi]),
            .ce_o      (ce_w[gi]),
            .we_o      (we_w[gi]),
            .q_i       (q_w[gi]),
            .m_valid_o (valid_w[gi]),
            .m_ready_i (ready),
            .m_data_o  (data_w[gi])
         );

         // BRAM model: data appears gi+1 cycles after ce; garbage otherwise.
         always @(posedge clk) begin
            pipe_v[0] <= ce_w[gi];
            pipe_d[0] <= mem[addr_w[gi]];
            pipe_v[1] <= pipe_v[0];
            pipe_d[1] <= pipe_d[0];
         end
         assign q_w[gi] = pipe_v[gi] ? pipe_d[gi] : 32'hDEAD_BEEF;

         // Monitor, sampled mid-cycle.
         always @(negedge clk) begin
            int idx;
            idx = cyc - base;
            if (ce_w[gi]) begin
               check_eq($sformatf("L%0d addr", gi + 1), 64'(addr_w[gi]), 64'(n_ce[gi] % 256));
               check_eq($sformatf("L%0d we", gi + 1), 64'(we_w[gi]), 64'd0);
               n_ce[gi]++;
               check_eq($sformatf("L%0d credit", gi + 1), 64'(n_ce[gi] - n_acc[gi] <= FD), 64'd1);
               if (first_ce[gi] < 0) first_ce[gi] = idx;
               last_ce[gi] = idx;
            end
            if (valid_w[gi] && first_v[gi] < 0) first_v[gi] = idx;
            if (hold_v[gi] && valid_w[gi])
               check_eq($sformatf("L%0d hold", gi + 1), 64'(data_w[gi]), 64'(hold_d[gi]));
            hold_v[gi] = valid_w[gi] && !ready;
            hold_d[gi] = data_w[gi];
            if (valid_w[gi] && ready) begin
               check_eq($sformatf("L%0d data", gi + 1), 64'(data_w[gi]), 64'(mem[n_acc[gi] % 256]));
               n_acc[gi]++;
            end
            if (done_w[gi]) begin
               n_done[gi]++;
               done_cyc[gi] = idx;
            end
         end
      end
   endgenerate

   task automatic clear_records();
      for (int g = 0; g < 2; g++) begin
         n_ce[g] = 0; n_acc[g] = 0; n_done[g] = 0;
         first_ce[g] = -1; last_ce[g] = -1; first_v[g] = -1; done_cyc[g] = -1;
         hold_v[g] = 1'b0; hold_d[g] = '0;
      end
   endtask

   task automatic check_reset(input string tag);
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("%s L%0d idle", tag, g + 1), 64'(idle_w[g]), 64'd1);
         check_eq($sformatf("%s L%0d running", tag, g + 1), 64'(running_w[g]), 64'd0);
         check_eq($sformatf("%s L%0d done", tag, g + 1), 64'(done_w[g]), 64'd0);
         check_eq($sformatf("%s L%0d ce", tag, g + 1), 64'(ce_w[g]), 64'd0);
         check_eq($sformatf("%s L%0d addr", tag, g + 1), 64'(addr_w[g]), 64'd0);
         check_eq($sformatf("%s L%0d valid", tag, g + 1), 64'(valid_w[g]), 64'd0);
         check_eq($sformatf("%s L%0d mdata", tag, g + 1), 64'(data_w[g]), 64'd0);
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: ready low for 10 cycles.
   task automatic run_one(input int num, input int mode, input bit seq_img);
      int  limit;
      bit  finished;
      limit    = 4 * num + 100;
      finished = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = seq_img ? 32'(i + 'h100) : $urandom;
      clear_records();
      @(posedge clk); #1;
      base    = cyc + 1;
      start   = 1'b1;
      num_cnt = (AW+1)'(num);
      ready   = (mode == 0);
      for (int k = 0; k < limit && !finished; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         case (mode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            default: ready = (k >= 10);
         endcase
         if (mode == 2 && k == 10) begin
            check_eq("stall L1 ce count", 64'(n_ce[0]), 64'(FD));
            check_eq("stall L2 ce count", 64'(n_ce[1]), 64'(FD));
         end
         if (n_done[0] > 0 && n_done[1] > 0) finished = 1'b1;
      end
      if (!finished) check_eq($sformatf("timeout num=%0d", num), 64'd0, 64'd1);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         int lat;
         lat = g + 1;
         check_eq($sformatf("n%0d L%0d idle after", num, lat), 64'(idle_w[g]), 64'd1);
         check_eq($sformatf("n%0d L%0d ce count", num, lat), 64'(n_ce[g]), 64'(num));
         check_eq($sformatf("n%0d L%0d words", num, lat), 64'(n_acc[g]), 64'(num));
         check_eq($sformatf("n%0d L%0d done pulses", num, lat), 64'(n_done[g]), 64'd1);
         if (mode == 0) begin
            if (num == 0) begin
               check_eq($sformatf("n0 L%0d done cycle", lat), 64'(done_cyc[g]), 64'd0);
               check_eq($sformatf("n0 L%0d no valid", lat), 64'(first_v[g]), 64'(-1));
            end else begin
               check_eq($sformatf("n%0d L%0d first ce", num, lat), 64'(first_ce[g]), 64'd0);
               check_eq($sformatf("n%0d L%0d last ce", num, lat), 64'(last_ce[g]), 64'(num - 1));
               check_eq($sformatf("n%0d L%0d first valid", num, lat), 64'(first_v[g]), 64'(lat + 1));
               check_eq($sformatf("n%0d L%0d done cycle", num, lat), 64'(done_cyc[g]), 64'(num + lat + 2));
            end
         end
      end
      $display("[TB] run num=%0d mode=%0d done, tests=%0d fails=%0d", num, mode, tests, fails);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      num_cnt = '0;
      ready   = 1'b0;
      clear_records();
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #2;
      check_reset("in reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_reset("after reset");

      run_one(4, 0, 1'b1);
      run_one(0, 0, 1'b0);
      run_one(256, 0, 1'b0);
      run_one(8, 2, 1'b0);
      run_one(37, 1, 1'b0);
      run_one(20, 1, 1'b0);

      // Abort a 10-word run halfway through with an asynchronous reset.
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      clear_records();
      @(posedge clk); #1;
      base    = cyc + 1;
      start   = 1'b1;
      num_cnt = (AW+1)'(10);
      ready   = 1'b1;
      begin
         int k;
         k = 0;
         do begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
         end while (n_acc[0] < 5 && k < 100);
         if (k >= 100) check_eq("abort timeout", 64'd0, 64'd1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_reset("abort");
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("abort L1 no done", 64'(n_done[0]), 64'd0);
      check_eq("abort L2 no done", 64'(n_done[1]), 64'd0);
      check_reset("abort released");

      run_one(3, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
